execute_unit: RTL and testbench
===============================

Name: execute_unit

Overview:
- Execute stage directly downstream of the 16x20-bit register file.
- Consumes the two read operands plus a decoded opcode and destination index, and computes a 20-bit result.
- Drives the register file write port (regwrite, regaddress, writedata).
- Single-cycle ALU ops, plus an iterative multi-cycle multiply; a valid/ready handshake stalls issue while the multiply runs.

Parameters:
- WIDTH, 20, datapath width; matches the register file word.
- AW, 4, register index width (16 registers).
- SHW, 5, shift-amount field width taken from op_b[SHW-1:0].

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented this cycle
- in_ready  out  1  unit can accept an operation this cycle
- opcode  in  4  operation select (codes in package)
- op_a  in  WIDTH  operand A (register file reg1out)
- op_b  in  WIDTH  operand B (register file reg2out)
- dest  in  AW  destination register index
- regwrite  out  1  one-cycle write strobe to register file
- regaddress  out  AW  write index
- writedata  out  WIDTH  write data
- zero  out  1  last written result == 0
- ovf  out  1  signed overflow of last ADD/SUB, else 0

Behaviour:
- Reset (async, rst_n=0) clears all state:
  - regwrite=0, regaddress=0, writedata=0, zero=0, ovf=0.
  - FSM=IDLE, so in_ready=1 once rst_n=1.
- Reset mid-multiply aborts the multiply; no write is ever issued for it.
- in_ready = (state==IDLE), combinational from state only.
- Accept: in_valid & in_ready sampled at a rising edge. in_valid while in_ready=0 is ignored, not queued.
- Opcodes:
  - 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR.
  - 6 SLL, 7 SRL, 8 SRA.
  - 9 SLT (signed, result 1/0), 10 MOV (=op_a), 11 MUL.
  - 12-15 reserved.
- Single-cycle ops accepted at edge N:
  - regwrite=1 for exactly the cycle after edge N.
  - writedata/regaddress valid in that same cycle.
  - Back-to-back issue every cycle is allowed.
- NOP and reserved opcodes are accepted, produce regwrite=0, and leave writedata/zero/ovf unchanged.
- ADD/SUB: result modulo 2^WIDTH; ovf = signed overflow. All other ops clear ovf.
- Shifts use op_b[SHW-1:0]. For amount >= WIDTH: SLL/SRL give 0, SRA gives all copies of op_a[WIDTH-1].
- zero is updated on every write: zero = (writedata==0).
- MUL (unsigned, low WIDTH bits of product) FSM:
  - IDLE -(accept MUL at edge N)-> MUL: latch multiplicand, multiplier and dest; count=0.
  - MUL: one shift-add step per edge; count increments.
  - At edge N+WIDTH, transition MUL -> IDLE and regwrite=1 for the following cycle.
  - Latency is WIDTH cycles. in_ready is low after edge N until after edge N+WIDTH.
  - A new op may be accepted in the same cycle the MUL result strobe is high.
- writedata/regaddress hold their value between strobes; the register file only samples them when regwrite=1.
- dest=0 is an ordinary register (no hardwired zero).

Decomposition:
- Shared package holds:
  - opcode constants (OP_NOP..OP_MUL);
  - WIDTH/AW defaults;
  - FSM state encoding (ST_IDLE, ST_MUL).
- One sub-module, seq_multiplier: start/busy/done handshake, WIDTH-step shift-add, low-half product out.
- ALU combinational logic and output registers live in execute_unit.

Test Plan:
- Reset mid-stream: drive ops, pull rst_n low asynchronously between edges -> outputs 0 immediately, in_ready=1 after release, no spurious regwrite.
- ADD, a=0x7FFFF, b=1, dest=3 -> one cycle later regwrite=1, regaddress=3, writedata=0x80000, ovf=1, zero=0. Then SUB 5-5, dest=4 -> writedata=0, zero=1, ovf=0.
- Shifts, a=0x80001:
  - SRA by 4 -> 0xF8000;
  - SRL by 4 -> 0x08000;
  - SLL by 25 -> 0;
  - SRA by 31 -> 0xFFFFF.
- MUL 0x00123 x 0x00456 dest=7, with in_valid held high on a following ADD:
  - in_ready low for 20 cycles;
  - regwrite pulses exactly once, 20 cycles after accept, writedata=0x4EDC2, regaddress=7;
  - the held ADD is accepted that same cycle and writes the next cycle.
- MUL 0xFFFFF x 0xFFFFF -> writedata=0x00001. Reset asserted at iteration 10 of a second MUL -> no regwrite ever for it.
- Back-to-back stream: AND, OR, XOR, SLT(-1<2 -> 1), MOV, NOP, opcode 14 on consecutive cycles -> five strobes on consecutive cycles; NOP and reserved opcode produce none and leave writedata unchanged.

Source files
------------

// File: rtl/execute_unit_pkg.sv
// rtl/execute_unit_pkg.sv - shared opcodes, widths and FSM encoding for the execute stage
package execute_unit_pkg;

   localparam int WIDTH_DEF = 20;
   localparam int AW_DEF    = 4;
   localparam int SHW_DEF   = 5;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;
   localparam logic [3:0] OP_SLL = 4'd6;
   localparam logic [3:0] OP_SRL = 4'd7;
   localparam logic [3:0] OP_SRA = 4'd8;
   localparam logic [3:0] OP_SLT = 4'd9;
   localparam logic [3:0] OP_MOV = 4'd10;
   localparam logic [3:0] OP_MUL = 4'd11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

   // Opcodes that write the register file one cycle after acceptance.
   function automatic logic is_single_op(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_MOV);
   endfunction

endpackage

// File: rtl/execute_unit_mul.sv
// rtl/execute_unit_mul.sv - iterative shift-add multiplier, low WIDTH bits of the product
module seq_multiplier
   import execute_unit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] product_o
);

   localparam int CW = $clog2(WIDTH + 1);

   logic             busy_q, busy_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] step_sum;

   // product_o is the accumulator after the step taken at the coming edge,
   // so the final result is visible while done_o is high.
   assign step_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign done_o    = busy_q && (count_q == CW'(WIDTH - 1));
   assign busy_o    = busy_q;
   assign product_o = step_sum;

   always_comb begin
      busy_d   = busy_q;
      count_d  = count_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      if (busy_q) begin
         acc_d    = step_sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         count_d  = count_q + 1'b1;
         if (done_o) busy_d = 1'b0;
      end else if (start_i) begin
         busy_d   = 1'b1;
         count_d  = '0;
         mcand_d  = a_i;
         mplier_d = b_i;
         acc_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= 1'b0;
         count_q  <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         busy_q   <= busy_d;
         count_q  <= count_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

endmodule

// File: rtl/execute_unit.sv
// rtl/execute_unit.sv - execute stage: single-cycle ALU, multi-cycle multiply, register file write port
module execute_unit
   import execute_unit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int AW    = AW_DEF,
   parameter int SHW   = SHW_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [AW-1:0]    dest,
   output logic             regwrite,
   output logic [AW-1:0]    regaddress,
   output logic [WIDTH-1:0] writedata,
   output logic             zero,
   output logic             ovf
);

   state_e           state_q, state_d;
   logic             regwrite_q, regwrite_d;
   logic [AW-1:0]    regaddress_q, regaddress_d;
   logic [WIDTH-1:0] writedata_q, writedata_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic [AW-1:0]    mul_dest_q, mul_dest_d;

   logic             accept;
   logic             mul_start, mul_busy, mul_done;
   logic [WIDTH-1:0] mul_product;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
   logic [WIDTH-1:0] sum, diff;
   logic [SHW-1:0]   sh;
   logic             sh_big;

   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (opcode == OP_MUL);

   seq_multiplier #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (mul_start),
      .a_i       (op_a),
      .b_i       (op_b),
      .busy_o    (mul_busy),
      .done_o    (mul_done),
      .product_o (mul_product)
   );

   assign sum    = op_a + op_b;
   assign diff   = op_a - op_b;
   assign sh     = op_b[SHW-1:0];
   assign sh_big = (32'(sh) >= WIDTH);

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      unique case (opcode)
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_SLL:  alu_res = sh_big ? '0 : (op_a << sh);
         OP_SRL:  alu_res = sh_big ? '0 : (op_a >> sh);
         OP_SRA:  alu_res = sh_big ? {WIDTH{op_a[WIDTH-1]}} : WIDTH'($signed(op_a) >>> sh);
         OP_SLT:  alu_res = WIDTH'($signed(op_a) < $signed(op_b));
         OP_MOV:  alu_res = op_a;
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (mul_start) state_d = ST_MUL;
         ST_MUL:  if (mul_done || !mul_busy) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign in_ready = (state_q == ST_IDLE);

   // Write-port register next state; outputs hold between strobes.
   always_comb begin
      regwrite_d   = 1'b0;
      regaddress_d = regaddress_q;
      writedata_d  = writedata_q;
      zero_d       = zero_q;
      ovf_d        = ovf_q;
      mul_dest_d   = mul_dest_q;
      if ((state_q == ST_MUL) && mul_done) begin
         regwrite_d   = 1'b1;
         regaddress_d = mul_dest_q;
         writedata_d  = mul_product;
         zero_d       = (mul_product == '0);
         ovf_d        = 1'b0;
      end else if (accept && is_single_op(opcode)) begin
         regwrite_d   = 1'b1;
         regaddress_d = dest;
         writedata_d  = alu_res;
         zero_d       = (alu_res == '0);
         ovf_d        = alu_ovf;
      end
      if (mul_start) mul_dest_d = dest;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regwrite_q   <= 1'b0;
         regaddress_q <= '0;
         writedata_q  <= '0;
         zero_q       <= 1'b0;
         ovf_q        <= 1'b0;
         mul_dest_q   <= '0;
      end else begin
         regwrite_q   <= regwrite_d;
         regaddress_q <= regaddress_d;
         writedata_q  <= writedata_d;
         zero_q       <= zero_d;
         ovf_q        <= ovf_d;
         mul_dest_q   <= mul_dest_d;
      end
   end

   assign regwrite   = regwrite_q;
   assign regaddress = regaddress_q;
   assign writedata  = writedata_q;
   assign zero       = zero_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_execute_unit.sv
// tb/tb_execute_unit.sv - directed self-checking bench for execute_unit
module tb_execute_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  opcode;
   logic [19:0] op_a, op_b;
   logic [3:0]  dest;
   logic        regwrite;
   logic [3:0]  regaddress;
   logic [19:0] writedata;
   logic        zero, ovf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   execute_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .opcode     (opcode),
      .op_a       (op_a),
      .op_b       (op_b),
      .dest       (dest),
      .regwrite   (regwrite),
      .regaddress (regaddress),
      .writedata  (writedata),
      .zero       (zero),
      .ovf        (ovf)
   );

   task automatic drive(input logic v, input logic [3:0] op, input logic [19:0] a,
                        input logic [19:0] b, input logic [3:0] d);
      in_valid = v;
      opcode   = op;
      op_a     = a;
      op_b     = b;
      dest     = d;
   endtask

   task automatic test_reset;
      drive(1'b0, 4'd0, 20'h0, 20'h0, 4'd0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({regwrite, regaddress, writedata, zero, ovf} !== 27'd0) begin
         errors++;
         $display("FAIL reset_outputs: got rw=%b ra=%h wd=%h z=%b o=%b, want all 0",
                  regwrite, regaddress, writedata, zero, ovf);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_reset_midstream;
      drive(1'b1, 4'd1, 20'h00011, 20'h00022, 4'd6);
      @(negedge clk);
      drive(1'b1, 4'd4, 20'h00F00, 20'h0000F, 4'd2);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({regwrite, regaddress, writedata, zero, ovf} !== 27'd0) begin
         errors++;
         $display("FAIL midreset_async: got rw=%b ra=%h wd=%h, want all 0",
                  regwrite, regaddress, writedata);
      end
      drive(1'b0, 4'd0, 20'h0, 20'h0, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int strobes = 0;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (regwrite) strobes++;
         end
         checks++;
         if (strobes != 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_quiet: got strobes=%0d ready=%b, want 0 and 1", strobes, in_ready);
         end
      end
   endtask

   task automatic test_add_sub;
      drive(1'b1, 4'd1, 20'h7FFFF, 20'h00001, 4'd3);
      @(negedge clk);
      drive(1'b1, 4'd2, 20'h00005, 20'h00005, 4'd4);
      checks++;
      if ({regwrite, regaddress, writedata, ovf, zero} !== {1'b1, 4'd3, 20'h80000, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL add_ovf: got rw=%b ra=%h wd=%h o=%b z=%b, want 1 3 80000 1 0",
                  regwrite, regaddress, writedata, ovf, zero);
      end
      @(negedge clk);
      drive(1'b0, 4'd0, 20'h0, 20'h0, 4'd0);
      checks++;
      if ({regwrite, regaddress, writedata, ovf, zero} !== {1'b1, 4'd4, 20'h00000, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL sub_zero: got rw=%b ra=%h wd=%h o=%b z=%b, want 1 4 00000 0 1",
                  regwrite, regaddress, writedata, ovf, zero);
      end
      @(negedge clk);
   endtask

   task automatic test_shifts;
      logic [3:0]  ops [4] = '{4'd8, 4'd7, 4'd6, 4'd8};
      logic [19:0] amts[4] = '{20'd4, 20'd4, 20'd25, 20'd31};
      logic [19:0] exps[4] = '{20'hF8000, 20'h08000, 20'h00000, 20'hFFFFF};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, ops[i], 20'h80001, amts[i], 4'(i));
         @(negedge clk);
         checks++;
         if (regwrite !== 1'b1 || writedata !== exps[i] || regaddress !== 4'(i)) begin
            errors++;
            $display("FAIL shift_%0d: got rw=%b wd=%h ra=%h, want 1 %h %h",
                     i, regwrite, writedata, regaddress, exps[i], 4'(i));
         end
      end
      drive(1'b0, 4'd0, 20'h0, 20'h0, 4'd0);
      @(negedge clk);
   endtask

   task automatic test_mul_held;
      int low_cycles = 0;
      int early_strobes = 0;
      drive(1'b1, 4'd11, 20'h00123, 20'h00456, 4'd7);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 0) drive(1'b1, 4'd1, 20'h00002, 20'h00003, 4'd9);
         if (in_ready === 1'b0) low_cycles++;
         if (regwrite !== 1'b0) early_strobes++;
      end
      checks++;
      if (low_cycles != 20 || early_strobes != 0) begin
         errors++;
         $display("FAIL mul_stall: got ready_low=%0d strobes=%0d, want 20 0", low_cycles, early_strobes);
      end
      @(negedge clk);
      checks++;
      if ({regwrite, regaddress, writedata, in_ready} !== {1'b1, 4'd7, 20'h4EDC2, 1'b1}) begin
         errors++;
         $display("FAIL mul_result: got rw=%b ra=%h wd=%h rdy=%b, want 1 7 4edc2 1",
                  regwrite, regaddress, writedata, in_ready);
      end
      @(negedge clk);
      drive(1'b0, 4'd0, 20'h0, 20'h0, 4'd0);
      checks++;
      if ({regwrite, regaddress, writedata} !== {1'b1, 4'd9, 20'h00005}) begin
         errors++;
         $display("FAIL mul_held_add: got rw=%b ra=%h wd=%h, want 1 9 00005",
                  regwrite, regaddress, writedata);
      end
      @(negedge clk);
   endtask

   task automatic test_mul_wrap_and_abort;
      int lat = -1;
      drive(1'b1, 4'd11, 20'hFFFFF, 20'hFFFFF, 4'd1);
      @(negedge clk);
      drive(1'b0, 4'd0, 20'h0, 20'h0, 4'd0);
      for (int i = 1; i <= 40 && lat < 0; i++) begin
         @(negedge clk);
         if (regwrite) lat = i;
      end
      checks++;
      if (lat != 20 || writedata !== 20'h00001 || zero !== 1'b0) begin
         errors++;
         $display("FAIL mul_wrap: got latency=%0d wd=%h z=%b, want 20 00001 0", lat, writedata, zero);
      end
      drive(1'b1, 4'd11, 20'h00003, 20'h00005, 4'd2);
      @(negedge clk);
      drive(1'b0, 4'd0, 20'h0, 20'h0, 4'd0);
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int strobes = 0;
         for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (regwrite) strobes++;
         end
         checks++;
         if (strobes != 0 || in_ready !== 1'b1 || writedata !== 20'h0) begin
            errors++;
            $display("FAIL mul_abort: got strobes=%0d rdy=%b wd=%h, want 0 1 00000",
                     strobes, in_ready, writedata);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0]  ops [7] = '{4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd0, 4'd14};
      logic [19:0] as  [7] = '{20'hF0F0F, 20'hF0F0F, 20'hF0F0F, 20'hFFFFF, 20'h12345, 20'h00000, 20'h00000};
      logic [19:0] bs  [7] = '{20'h0FF00, 20'h0FF00, 20'h0FF00, 20'h00002, 20'h00000, 20'h00000, 20'h00000};
      logic [19:0] exps[7] = '{20'h00F00, 20'hFFF0F, 20'hFF00F, 20'h00001, 20'h12345, 20'h12345, 20'h12345};
      logic        rws [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, ops[i], as[i], bs[i], 4'(i + 8));
         @(negedge clk);
         checks++;
         if (regwrite !== rws[i] || writedata !== exps[i] || (rws[i] && regaddress !== 4'(i + 8))) begin
            errors++;
            $display("FAIL b2b_%0d: got rw=%b wd=%h ra=%h, want %b %h %h",
                     i, regwrite, writedata, regaddress, rws[i], exps[i], 4'(i + 8));
         end
      end
      drive(1'b0, 4'd0, 20'h0, 20'h0, 4'd0);
      @(negedge clk);
      checks++;
      if (regwrite !== 1'b0 || regaddress !== 4'd12 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL b2b_hold: got rw=%b ra=%h o=%b, want 0 c 0", regwrite, regaddress, ovf);
      end
   endtask

   initial begin
      test_reset();
      test_reset_midstream();
      test_add_sub();
      test_shifts();
      test_mul_held();
      test_mul_wrap_and_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
